// File: rtl/video_pattern_ctrl.sv
// 640x480 raster timing plus frame-synchronous pattern selection.
// Button and auto-cycle requests take effect only at frame boundaries.
module video_pattern_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vde,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       pattern_sel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(AUTO_FRAMES + 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(AUTO_FRAMES - 1);

  typedef enum logic {WAIT, ARMED} state_t;

  logic [9:0] h_q, v_q;
  logic       h_wrap, fb;

  assign h_wrap = (h_q == H_LAST);
  assign fb     = h_wrap && (v_q == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap)
        v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  logic       vde_d;
  logic [9:0] x_q, y_q;
  logic       vde_q, hs_q, vs_q, fs_q, psel_q;

  assign vde_d = (h_q < H_ACT) && (v_q < V_ACT);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      vde_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= vde_d ? h_q : 10'd0;
      y_q   <= vde_d ? v_q : 10'd0;
      vde_q <= vde_d;
      hs_q  <= !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_q  <= !((v_q >= VS_BEG) && (v_q < VS_END));
      fs_q  <= (h_q == 10'd0) && (v_q == 10'd0);
    end
  end

  // Level changes only after a full run of samples disagreeing with it.
  logic          s1_q, s2_q, lvl_q, db_rise;
  logic [DW-1:0] dbc_q;

  assign db_rise = s2_q && !lvl_q && (dbc_q == D_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      dbc_q <= '0;
    end else begin
      s1_q <= btn_next;
      s2_q <= s1_q;
      if (s2_q != lvl_q) begin
        if (dbc_q == D_LAST) begin
          lvl_q <= s2_q;
          dbc_q <= '0;
        end else begin
          dbc_q <= dbc_q + 1'b1;
        end
      end else begin
        dbc_q <= '0;
      end
    end
  end

  state_t        state_q, state_d;
  logic          sel_q, sel_d, pend_q, pend_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q | db_rise;
    fcnt_d  = fcnt_q;
    if (!auto_en)
      fcnt_d = '0;
    else if (fb && fcnt_q != F_LAST)
      fcnt_d = fcnt_q + 1'b1;
    unique case (state_q)
      WAIT: begin
        if (pend_q || (auto_en && fcnt_q == F_LAST))
          state_d = ARMED;
      end
      ARMED: begin
        if (fb) begin
          state_d = WAIT;
          sel_d   = ~sel_q;
          pend_d  = db_rise;
          fcnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
      psel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      psel_q  <= sel_q;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign vde         = vde_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign pattern_sel = psel_q;

endmodule

// File: tb/tb_video_pattern_ctrl.sv
// Scoreboard bench: raster checked against cycle arithmetic, pattern
// selection against a frame-level model of requests and auto-cycling.
module tb_video_pattern_ctrl;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int DC = 4, AF = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst, btn_next, auto_en;
  logic [9:0] x, y;
  logic       vde, hsync, vsync, frame_start, pattern_sel;

  video_pattern_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .DEBOUNCE_CYCLES(DC), .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .auto_en(auto_en),
    .x(x), .y(y), .vde(vde), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .pattern_sel(pattern_sel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];
  bit cur_sel = 1'b0;

  // frame-level reference state
  bit m_sel, m_armed;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: outputs are a function of clocks elapsed since reset
  initial begin : mon
    logic r;
    int t, h, v;
    logic [24:0] e;
    logic ev;
    t = 0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) begin
        chk("reset_outputs",
            {7'd0, x, y, vde, hsync, vsync, frame_start, pattern_sel},
            {7'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        t = 0;
        cur_sel = 1'b0;
      end else begin
        h = t % HT;
        v = (t / HT) % VT;
        ev = (h < HA) && (v < VA);
        e = {ev ? 10'(h) : 10'd0, ev ? 10'(v) : 10'd0, ev,
             !((h >= HA + HFP) && (h < HA + HFP + HS)),
             !((v >= VA + VFP) && (v < VA + VFP + VS)),
             (h == 0) && (v == 0)};
        chk("raster", {8'd0, x, y, vde, hsync, vsync, frame_start},
            {8'd0, e[23:0]});
        if (h == 0 && v == 0) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sel_queue: got empty expected entry at %0t",
                     $time);
          end else begin
            cur_sel = exp_q.pop_front();
            chk("sel_at_frame_start", 32'(pattern_sel), 32'(cur_sel));
          end
        end else begin
          chk("sel_hold", 32'(pattern_sel), 32'(cur_sel));
        end
        t++;
      end
    end
  end

  task automatic model_reset();
    m_sel = 1'b0;
    m_armed = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
  endtask

  // one frame of stimulus, then the frame-boundary decision
  task automatic run_frame(input bit p1, input bit bounce, input int p1c,
                           input bit p2, input bit new_auto);
    bit press;
    for (int c = 0; c < FT; c++) begin
      @(negedge clk);
      if (p1 && c == p1c) btn_next = 1'b1;
      if (p1 && c == p1c + (bounce ? 3 : 10)) btn_next = 1'b0;
      if (p2 && c == 160) btn_next = 1'b1;
      if (p2 && c == 170) btn_next = 1'b0;
      if (c == 240) auto_en = new_auto;
    end
    press = (p1 && !bounce) || p2;
    if (m_armed || press) begin
      m_sel = !m_sel;
      m_cnt = 0;
    end else if (auto_en) begin
      m_cnt = (m_cnt + 1 > AF - 1) ? AF - 1 : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    m_armed = auto_en && (m_cnt == AF - 1);
    exp_q.push_back(m_sel);
  endtask

  initial begin : stim
    rst = 1'b1;
    btn_next = 1'b0;
    auto_en = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;

    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 1, 50, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 0, 60, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    repeat (5) run_frame(0, 0, 0, 0, 1);
    run_frame(0, 0, 0, 0, 0);
    repeat (4) run_frame(0, 0, 0, 0, 1);
    for (int i = 0; i < 4 && !m_armed; i++) run_frame(0, 0, 0, 0, 1);
    run_frame(1, 0, 40, 1, 1);
    run_frame(0, 0, 0, 0, 1);

    for (int i = 0; i < 30; i++)
      run_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(20, 120), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0);

    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    if (!m_sel) run_frame(1, 0, 30, 0, 0);
    run_frame(0, 0, 0, 0, 0);

    // press mid-frame so a toggle is pending, then reset
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      if (c == 20) btn_next = 1'b1;
      if (c == 30) btn_next = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
